switch_debouncer: RTL

Multi-channel push-button conditioner for the iCE40 board designs. Each raw, asynchronous, bouncing switch input passes through a two-flop synchronizer and a stability counter. The block produces a clean level plus single-cycle rise/fall strobes. It sits directly upstream of the ring-counter/LED stages, which consume `sw_rise` as their advance or reset request instead of the raw pin.

---
 rtl/switch_debouncer.sv | 104 ++++++++++
 1 files changed

// File: rtl/switch_debouncer.sv
// switch_debouncer: multi-channel push-button conditioner.
// Each raw switch pin is brought into the clk domain through a two-flop
// synchronizer, then must hold a new level for DEBOUNCE_CYCLES consecutive
// synchronized cycles before the debounced level follows it.
//
// Ports:
//   clk      - system clock, all logic on the rising edge
//   rst_n    - synchronous active-low reset
//   sw_raw   - raw, asynchronous, bouncing switch pins (1 = pressed)
//   sw_db    - debounced level per channel
//   sw_rise  - one-cycle strobe coincident with sw_db going 0->1
//   sw_fall  - one-cycle strobe coincident with sw_db going 1->0
module switch_debouncer #(
    parameter int unsigned NUM_SW          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SW-1:0] sw_raw,
    output logic [NUM_SW-1:0] sw_db,
    output logic [NUM_SW-1:0] sw_rise,
    output logic [NUM_SW-1:0] sw_fall
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Per-channel mode, decoded from the synchronized level versus the accepted level
    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } ch_state_e;

    logic [NUM_SW-1:0] r_s1;
    logic [NUM_SW-1:0] r_s2;
    logic [NUM_SW-1:0] r_db;
    logic [NUM_SW-1:0] r_rise;
    logic [NUM_SW-1:0] r_fall;
    logic [CNT_W-1:0]  r_cnt [NUM_SW];

    ch_state_e         w_state [NUM_SW];
    logic [NUM_SW-1:0] w_db_nxt;
    logic [NUM_SW-1:0] w_rise_nxt;
    logic [NUM_SW-1:0] w_fall_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt [NUM_SW];

    // Next-state logic: count while the synchronized level disagrees, accept at terminal count
    always_comb begin
        w_db_nxt   = r_db;
        w_rise_nxt = '0;
        w_fall_nxt = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            w_cnt_nxt[i] = '0;
            w_state[i]   = (r_s2[i] != r_db[i]) ? ST_COUNTING : ST_STABLE;
            case (w_state[i])
                ST_STABLE: begin
                    // A level that reverted before acceptance lands here and the count restarts
                    w_cnt_nxt[i] = '0;
                end
                ST_COUNTING: begin
                    if (r_cnt[i] == CNT_MAX) begin
                        w_db_nxt[i]   = r_s2[i];
                        w_rise_nxt[i] = r_s2[i];
                        w_fall_nxt[i] = ~r_s2[i];
                        w_cnt_nxt[i]  = '0;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                    end
                end
                default: begin
                    w_cnt_nxt[i] = '0;
                end
            endcase
        end
    end

    // Synchronizer, accepted level, strobes and counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_db   <= '0;
            r_rise <= '0;
            r_fall <= '0;
            for (int i = 0; i < NUM_SW; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1   <= sw_raw;
            r_s2   <= r_s1;
            r_db   <= w_db_nxt;
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
            for (int i = 0; i < NUM_SW; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign sw_db   = r_db;
    assign sw_rise = r_rise;
    assign sw_fall = r_fall;

endmodule
